// File: rtl/bcd_convert_arbiter.sv
// Shared iterative binary-to-BCD converter (double-dabble, one bit per clock)
// serving two requesters through a round-robin arbiter.
module bcd_convert_arbiter #(
    parameter int unsigned N      = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [N-1:0]          bin0,
    input  logic                  req1,
    input  logic [N-1:0]          bin1,
    output logic                  grant0,
    output logic                  grant1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned NDIG  = DIGITS + 1;
    localparam int unsigned REG_W = 4 * NDIG;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state_q, state_d;
    logic [REG_W-1:0]     sreg_q, sreg_d;
    logic [N-1:0]         src_q, src_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic                 grant0_d, grant1_d, busy_d, done_d, done_id_d, ovf_d;
    logic [BCD_W-1:0]     bcd_d;
    logic [REG_W-1:0]     corr;
    logic [REG_W-1:0]     shifted;
    logic                 pick1;

    // Per-digit add-3 correction followed by the MSB-first shift of one operand bit
    always_comb begin
        corr = sreg_q;
        for (int unsigned d = 0; d < NDIG; d++) begin
            if (sreg_q[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = sreg_q[4*d +: 4] + 4'd3;
            end
        end
        shifted = {corr[REG_W-2:0], src_q[cnt_q]};
    end

    // Tie goes to whoever was not served last; last_q resets to 1 so req0 wins first
    assign pick1 = req1 && (!req0 || !last_q);

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        done_id_d = done_id;
        bcd_d     = bcd_out;
        ovf_d     = ovf;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d  = pick1;
                    src_d    = pick1 ? bin1 : bin0;
                    sreg_d   = '0;
                    cnt_d    = CNT_W'(N - 1);
                    grant0_d = !pick1;
                    grant1_d = pick1;
                    busy_d   = 1'b1;
                    state_d  = CONV;
                end
            end
            CONV: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    bcd_d     = shifted[BCD_W-1:0];
                    ovf_d     = |shifted[REG_W-1 -: 4];
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    last_d    = owner_q;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant0  <= 1'b0;
            grant1  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant0  <= grant0_d;
            grant1  <= grant1_d;
            busy    <= busy_d;
            done    <= done_d;
            done_id <= done_id_d;
            bcd_out <= bcd_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter: arbitration, latency,
// conversion values, overflow, mid-conversion reset and back-to-back throughput.
module tb_bcd_convert_arbiter;

    localparam int unsigned N      = 20;
    localparam int unsigned DIGITS = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0, req1;
    logic [N-1:0]        bin0, bin1;
    logic                grant0, grant1, busy, done, done_id, ovf;
    logic [4*DIGITS-1:0] bcd_out;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_convert_arbiter #(.N(N), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .grant0(grant0), .grant1(grant1), .busy(busy), .done(done),
        .done_id(done_id), .bcd_out(bcd_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Counts falling edges until done is seen (bounded at 100)
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done !== 1'b1 && cycles < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({grant0, grant1} !== 2'b00) begin n_fail++; $display("FAIL reset_grants: got %b expected 00", {grant0, grant1}); end
        n_checks++; if ({bcd_out, ovf, done_id} !== 26'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", {bcd_out, ovf, done_id}); end
        rst = 1'b0;
    endtask

    task automatic test_tie();
        logic [23:0] exp_bcd [4] = '{24'h000001, 24'h000002, 24'h000001, 24'h000002};
        int cyc;
        @(negedge clk);
        req0 = 1'b1; bin0 = 20'd1; req1 = 1'b1; bin1 = 20'd2;
        @(negedge clk);
        n_checks++; if ({grant0, grant1} !== 2'b10) begin n_fail++; $display("FAIL tie_first_grant: got %b expected 10", {grant0, grant1}); end
        for (int k = 0; k < 4; k++) begin
            wait_done(cyc);
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            n_checks++; if (cyc != ((k == 0) ? 20 : 21)) begin n_fail++; $display("FAIL tie_latency_%0d: got %0d expected %0d", k, cyc, (k == 0) ? 20 : 21); end
            n_checks++; if (done_id !== 1'(k % 2)) begin n_fail++; $display("FAIL tie_id_%0d: got %b expected %0d", k, done_id, k % 2); end
            n_checks++; if (bcd_out !== exp_bcd[k]) begin n_fail++; $display("FAIL tie_bcd_%0d: got %h expected %h", k, bcd_out, exp_bcd[k]); end
        end
    endtask

    task automatic test_single();
        int cyc;
        @(negedge clk);
        req0 = 1'b1; bin0 = 20'd12345;
        @(negedge clk);
        req0 = 1'b0;
        n_checks++; if ({grant0, grant1, busy} !== 3'b101) begin n_fail++; $display("FAIL single_grant: got %b expected 101", {grant0, grant1, busy}); end
        @(negedge clk);
        n_checks++; if (grant0 !== 1'b0) begin n_fail++; $display("FAIL single_grant_pulse: got %b expected 0", grant0); end
        wait_done(cyc);
        n_checks++; if (cyc != 19) begin n_fail++; $display("FAIL single_latency: got %0d expected 19", cyc); end
        n_checks++; if ({bcd_out, ovf, done_id} !== {24'h012345, 1'b0, 1'b0}) begin n_fail++; $display("FAIL single_result: got %h/%b/%b expected 012345/0/0", bcd_out, ovf, done_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear: got %b expected 0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || bcd_out !== 24'h012345) begin n_fail++; $display("FAIL single_done_pulse: got done=%b bcd=%h expected 0/012345", done, bcd_out); end
    endtask

    task automatic test_values();
        logic [N-1:0]  vin  [3] = '{20'd999999, 20'd1048575, 20'd0};
        logic [23:0]   vbcd [3] = '{24'h999999, 24'h048575, 24'h000000};
        logic          vovf [3] = '{1'b0, 1'b1, 1'b0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0 = 1'b1; bin0 = vin[i];
            @(negedge clk);
            req0 = 1'b0;
            wait_done(cyc);
            n_checks++; if (cyc != 20) begin n_fail++; $display("FAIL value_latency_%0d: got %0d expected 20", i, cyc); end
            n_checks++; if (bcd_out !== vbcd[i]) begin n_fail++; $display("FAIL value_bcd_%0d: got %h expected %h", i, bcd_out, vbcd[i]); end
            n_checks++; if (ovf !== vovf[i]) begin n_fail++; $display("FAIL value_ovf_%0d: got %b expected %b", i, ovf, vovf[i]); end
        end
    endtask

    task automatic test_mid_request();
        int cyc = 0;
        int early = 0;
        @(negedge clk);
        req0 = 1'b1; bin0 = 20'd7;
        @(negedge clk);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        req1 = 1'b1; bin1 = 20'd55;
        do begin
            @(negedge clk);
            cyc++;
            if (grant1 !== 1'b0) early++;
        end while (done !== 1'b1 && cyc < 100);
        n_checks++; if (early != 0 || cyc >= 100) begin n_fail++; $display("FAIL mid_no_grant_while_busy: got %0d early grants, %0d cycles expected 0 early", early, cyc); end
        n_checks++; if ({bcd_out, done_id} !== {24'h000007, 1'b0}) begin n_fail++; $display("FAIL mid_first_result: got %h/%b expected 000007/0", bcd_out, done_id); end
        @(negedge clk);
        req1 = 1'b0;
        n_checks++; if ({grant0, grant1} !== 2'b01) begin n_fail++; $display("FAIL mid_grant1_timing: got %b expected 01", {grant0, grant1}); end
        wait_done(cyc);
        n_checks++; if ({bcd_out, done_id} !== {24'h000055, 1'b1}) begin n_fail++; $display("FAIL mid_second_result: got %h/%b expected 000055/1", bcd_out, done_id); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int cyc;
        @(negedge clk);
        req0 = 1'b1; bin0 = 20'd123456;
        @(negedge clk);
        req0 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({busy, done, ovf} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 000", {busy, done, ovf}); end
        n_checks++; if (bcd_out !== 24'h0) begin n_fail++; $display("FAIL rstmid_bcd: got %h expected 000000", bcd_out); end
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", pulses); end
        req0 = 1'b1; bin0 = 20'd42;
        @(negedge clk);
        req0 = 1'b0;
        n_checks++; if (grant0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant: got %b expected 1", grant0); end
        wait_done(cyc);
        n_checks++; if (bcd_out !== 24'h000042 || cyc != 20) begin n_fail++; $display("FAIL rstmid_result: got %h after %0d expected 000042 after 20", bcd_out, cyc); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] vin  [4] = '{20'd4321, 20'd87, 20'd65536, 20'd9};
        logic [23:0]  vbcd [3] = '{24'h004321, 24'h000087, 24'h065536};
        int t = 0;
        int ng = 0;
        int nd = 0;
        int last_t = 0;
        @(negedge clk);
        req0 = 1'b1; bin0 = vin[0];
        while (nd < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (grant0 === 1'b1 && ng < 3) begin ng++; bin0 = vin[ng]; end
            if (done === 1'b1) begin
                if (nd == 2) req0 = 1'b0;
                n_checks++; if (bcd_out !== vbcd[nd]) begin n_fail++; $display("FAIL b2b_bcd_%0d: got %h expected %h", nd, bcd_out, vbcd[nd]); end
                if (nd > 0) begin
                    n_checks++; if (t - last_t != 21) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected 21", nd, t - last_t); end
                end
                last_t = t;
                nd++;
            end
        end
        req0 = 1'b0;
        n_checks++; if (nd != 3) begin n_fail++; $display("FAIL b2b_count: got %0d dones expected 3", nd); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_values();
        test_mid_request();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
